// File: rtl/micro_ucr_nonce_ctrl.sv
// micro_ucr_nonce_ctrl: drives the micro_ucr_hash core with header plus an incrementing nonce
// and stops on the first nonce whose hash bytes 0 and 1 are both below the target.
module micro_ucr_nonce_ctrl #(
    parameter int          HASH_LAT    = 20,
    parameter logic [31:0] NONCE_LIMIT = 32'h0000_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  header0,
    input  logic [7:0]  header1,
    input  logic [7:0]  header2,
    input  logic [7:0]  header3,
    input  logic [7:0]  header4,
    input  logic [7:0]  header5,
    input  logic [7:0]  header6,
    input  logic [7:0]  header7,
    input  logic [7:0]  header8,
    input  logic [7:0]  header9,
    input  logic [7:0]  header10,
    input  logic [7:0]  header11,
    input  logic [7:0]  target,
    input  logic [7:0]  hash_array0,
    input  logic [7:0]  hash_array1,
    input  logic [7:0]  hash_array2,
    output logic        ready,
    output logic [7:0]  array_numbers0,
    output logic [7:0]  array_numbers1,
    output logic [7:0]  array_numbers2,
    output logic [7:0]  array_numbers3,
    output logic [7:0]  array_numbers4,
    output logic [7:0]  array_numbers5,
    output logic [7:0]  array_numbers6,
    output logic [7:0]  array_numbers7,
    output logic [7:0]  array_numbers8,
    output logic [7:0]  array_numbers9,
    output logic [7:0]  array_numbers10,
    output logic [7:0]  array_numbers11,
    output logic [7:0]  array_numbers12,
    output logic [7:0]  array_numbers13,
    output logic [7:0]  array_numbers14,
    output logic [7:0]  array_numbers15,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [31:0] nonce,
    output logic [7:0]  hash_out0,
    output logic [7:0]  hash_out1,
    output logic [7:0]  hash_out2
);
    localparam int CW = HASH_LAT > 1 ? $clog2(HASH_LAT) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CHECK, DONE_OK, DONE_FAIL} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [95:0]   hdr;
    logic [7:0]    tgt;
    logic          pass, accept;

    assign pass   = (hash_array0 < tgt) && (hash_array1 < tgt);
    assign accept = start && (state == IDLE || state == DONE_OK || state == DONE_FAIL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        found    = 1'b0;
        unique case (state)
            IDLE:      state_nx = start ? LOAD : IDLE;
            LOAD: begin
                ready    = 1'b1;
                busy     = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                busy     = 1'b1;
                state_nx = cnt == '0 ? CHECK : WAIT;
            end
            CHECK: begin
                busy     = 1'b1;
                state_nx = pass ? DONE_OK : nonce == NONCE_LIMIT ? DONE_FAIL : LOAD;
            end
            DONE_OK: begin
                done     = 1'b1;
                found    = 1'b1;
                state_nx = start ? LOAD : DONE_OK;
            end
            DONE_FAIL: begin
                done     = 1'b1;
                state_nx = start ? LOAD : DONE_FAIL;
            end
            default:   state_nx = IDLE;
        endcase
    end

    // hash_out is cleared on every accepted start so a failed search reports zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr       <= '0;
            tgt       <= '0;
            nonce     <= '0;
            cnt       <= '0;
            hash_out0 <= '0;
            hash_out1 <= '0;
            hash_out2 <= '0;
        end else begin
            if (accept) begin
                hdr       <= {header0, header1, header2, header3, header4, header5,
                              header6, header7, header8, header9, header10, header11};
                tgt       <= target;
                nonce     <= '0;
                hash_out0 <= '0;
                hash_out1 <= '0;
                hash_out2 <= '0;
            end
            if (state == LOAD)      cnt <= CW'(HASH_LAT - 1);
            else if (state == WAIT) cnt <= cnt - 1'b1;
            if (state == CHECK) begin
                if (pass) begin
                    hash_out0 <= hash_array0;
                    hash_out1 <= hash_array1;
                    hash_out2 <= hash_array2;
                end else if (nonce != NONCE_LIMIT) begin
                    nonce <= nonce + 32'd1;
                end
            end
        end
    end

    assign array_numbers0  = hdr[95:88];
    assign array_numbers1  = hdr[87:80];
    assign array_numbers2  = hdr[79:72];
    assign array_numbers3  = hdr[71:64];
    assign array_numbers4  = hdr[63:56];
    assign array_numbers5  = hdr[55:48];
    assign array_numbers6  = hdr[47:40];
    assign array_numbers7  = hdr[39:32];
    assign array_numbers8  = hdr[31:24];
    assign array_numbers9  = hdr[23:16];
    assign array_numbers10 = hdr[15:8];
    assign array_numbers11 = hdr[7:0];
    assign array_numbers12 = nonce[31:24];
    assign array_numbers13 = nonce[23:16];
    assign array_numbers14 = nonce[15:8];
    assign array_numbers15 = nonce[7:0];
endmodule

// File: tb/tb_micro_ucr_nonce_ctrl.sv
// tb_micro_ucr_nonce_ctrl: directed bench with a hash-core stub keyed on the nonce operands;
// a second instance with NONCE_LIMIT=3 covers exhaustion.
module tb_micro_ucr_nonce_ctrl;
    logic        clk = 0, reset = 0, start = 0, start_x = 0;
    logic [7:0]  hdr [12];
    logic [7:0]  target = 0;
    logic [7:0]  ha [3], ho [3], an [16];
    logic [7:0]  hx = 8'hFF, ho_x [3], an_x [16];
    logic        ready, busy, done, found, ready_x, busy_x, done_x, found_x;
    logic [31:0] nonce, nonce_x;
    logic [31:0] win_n = 32'hFFFF_FFFF, fail_n = 32'hFFFF_FFFF;
    logic [23:0] wv = 24'h030FAA, fv = 24'h400000;
    int          n_chk = 0, n_err = 0;
    int          cyc = 0, rc = 0, rgap = 0, rlast = -1, rc_x = 0;
    int          base, base_x, gbase;

    always #5 clk = ~clk;

    micro_ucr_nonce_ctrl #(.HASH_LAT(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .header0(hdr[0]), .header1(hdr[1]), .header2(hdr[2]), .header3(hdr[3]),
        .header4(hdr[4]), .header5(hdr[5]), .header6(hdr[6]), .header7(hdr[7]),
        .header8(hdr[8]), .header9(hdr[9]), .header10(hdr[10]), .header11(hdr[11]),
        .target(target), .hash_array0(ha[0]), .hash_array1(ha[1]), .hash_array2(ha[2]),
        .ready(ready),
        .array_numbers0(an[0]), .array_numbers1(an[1]), .array_numbers2(an[2]), .array_numbers3(an[3]),
        .array_numbers4(an[4]), .array_numbers5(an[5]), .array_numbers6(an[6]), .array_numbers7(an[7]),
        .array_numbers8(an[8]), .array_numbers9(an[9]), .array_numbers10(an[10]), .array_numbers11(an[11]),
        .array_numbers12(an[12]), .array_numbers13(an[13]), .array_numbers14(an[14]), .array_numbers15(an[15]),
        .busy(busy), .done(done), .found(found), .nonce(nonce),
        .hash_out0(ho[0]), .hash_out1(ho[1]), .hash_out2(ho[2])
    );

    micro_ucr_nonce_ctrl #(.HASH_LAT(4), .NONCE_LIMIT(32'd3)) dut_x (
        .clk(clk), .reset(reset), .start(start_x),
        .header0(hdr[0]), .header1(hdr[1]), .header2(hdr[2]), .header3(hdr[3]),
        .header4(hdr[4]), .header5(hdr[5]), .header6(hdr[6]), .header7(hdr[7]),
        .header8(hdr[8]), .header9(hdr[9]), .header10(hdr[10]), .header11(hdr[11]),
        .target(target), .hash_array0(hx), .hash_array1(hx), .hash_array2(hx),
        .ready(ready_x),
        .array_numbers0(an_x[0]), .array_numbers1(an_x[1]), .array_numbers2(an_x[2]), .array_numbers3(an_x[3]),
        .array_numbers4(an_x[4]), .array_numbers5(an_x[5]), .array_numbers6(an_x[6]), .array_numbers7(an_x[7]),
        .array_numbers8(an_x[8]), .array_numbers9(an_x[9]), .array_numbers10(an_x[10]), .array_numbers11(an_x[11]),
        .array_numbers12(an_x[12]), .array_numbers13(an_x[13]), .array_numbers14(an_x[14]), .array_numbers15(an_x[15]),
        .busy(busy_x), .done(done_x), .found(found_x), .nonce(nonce_x),
        .hash_out0(ho_x[0]), .hash_out1(ho_x[1]), .hash_out2(ho_x[2])
    );

    // hash core stub: answers instantly, keyed on the nonce bytes it is handed
    always_comb begin
        {ha[0], ha[1], ha[2]} = 24'hFFFF00;
        if ({an[12], an[13], an[14], an[15]} == fail_n) {ha[0], ha[1], ha[2]} = fv;
        if ({an[12], an[13], an[14], an[15]} == win_n)  {ha[0], ha[1], ha[2]} = wv;
    end

    always @(negedge clk) begin
        cyc++;
        if (!busy) rlast = -1;
        if (ready) begin
            if (rlast >= 0 && cyc - rlast != 6) rgap++;
            rc++;
            rlast = cyc;
        end
        if (ready_x) rc_x++;
    end

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] an_hdr();
        logic [95:0] v = '0;
        for (int i = 0; i < 12; i++) v = {v[87:0], an[i]};
        return v;
    endfunction

    function automatic logic [95:0] hdr_pat(input logic [7:0] b);
        logic [95:0] v = '0;
        for (int i = 0; i < 12; i++) v = {v[87:0], b + 8'(i)};
        return v;
    endfunction

    function automatic logic [191:0] outs_all();
        logic [127:0] v = '0;
        for (int i = 0; i < 16; i++) v = {v[119:0], an[i]};
        return {4'h0, ready, busy, done, found, nonce, ho[0], ho[1], ho[2], v};
    endfunction

    task automatic set_hdr(input logic [7:0] b);
        for (int i = 0; i < 12; i++) hdr[i] = b + 8'(i);
    endtask

    task automatic wait_done(input string tag, input int lim);
        for (int i = 0; i < lim && !done; i++) @(negedge clk);
        chk(tag, done, 1'b1);
    endtask

    task automatic wait_done_x(input string tag);
        for (int i = 0; i < 100 && !done_x; i++) @(negedge clk);
        chk(tag, done_x, 1'b1);
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        set_hdr(8'h00);
        @(negedge clk);
        chk("reset_outputs", outs_all(), '0);
        reset = 1;
        @(negedge clk);
        // found at nonce 5, with an ignored start and header/target change during WAIT
        target = 8'h10; win_n = 32'd5;
        base = rc; gbase = rgap;
        pulse_start();
        chk("first_ready", {ready, busy, done}, 3'b110);
        chk("load_header", an_hdr(), hdr_pat(8'h00));
        @(negedge clk);
        start = 1; set_hdr(8'h10); target = 8'h00;
        @(negedge clk);
        start = 0;
        chk("wait_header_held", an_hdr(), hdr_pat(8'h00));
        chk("wait_no_ready", ready, 1'b0);
        wait_done("found_timeout", 200);
        chk("found_flags", {done, found, busy}, 3'b110);
        chk("found_nonce", nonce, 32'd5);
        chk("found_hash", {ho[0], ho[1], ho[2]}, 24'h030FAA);
        chk("found_ready_count", rc - base, 6);
        chk("found_ready_gap", rgap - gbase, 0);
        // restart from DONE_OK with the new header
        target = 8'h10; win_n = 32'd2; base = rc;
        pulse_start();
        chk("restart_load", {ready, done, found}, 3'b100);
        chk("restart_nonce", nonce, 32'd0);
        chk("restart_header", an_hdr(), hdr_pat(8'h10));
        wait_done("restart_timeout", 200);
        chk("restart_result", {found, nonce}, {1'b1, 32'd2});
        chk("restart_ready_count", rc - base, 3);
        // operand mapping at nonce 0x102
        set_hdr(8'h00); win_n = 32'h0000_0102;
        pulse_start();
        for (int i = 0; i < 2500 && !(ready && nonce == 32'h102); i++) @(negedge clk);
        chk("op_reached", {ready, nonce}, {1'b1, 32'h102});
        chk("op_nonce_bytes", {an[12], an[13], an[14], an[15]}, 32'h0000_0102);
        chk("op_header", an_hdr(), hdr_pat(8'h00));
        wait_done("op_timeout", 100);
        chk("op_result", {found, nonce}, {1'b1, 32'h102});
        // boundary: 40 vs target 40 fails, 3F/3F passes
        target = 8'h40; fail_n = 32'd0; fv = 24'h400000; win_n = 32'd1; wv = 24'h3F3F77;
        base = rc;
        pulse_start();
        wait_done("bnd_timeout", 200);
        chk("bnd_result", {found, nonce}, {1'b1, 32'd1});
        chk("bnd_hash", {ho[0], ho[1], ho[2]}, 24'h3F3F77);
        chk("bnd_ready_count", rc - base, 2);
        // exhaustion with NONCE_LIMIT=3
        target = 8'h10; hx = 8'hFF; base_x = rc_x;
        start_x = 1; @(negedge clk); start_x = 0;
        wait_done_x("exh_timeout");
        chk("exh_flags", {done_x, found_x, busy_x}, 3'b100);
        chk("exh_nonce", nonce_x, 32'd3);
        chk("exh_hash", {ho_x[0], ho_x[1], ho_x[2]}, 24'h0);
        chk("exh_ready_count", rc_x - base_x, 4);
        target = 8'h00; hx = 8'h00; base_x = rc_x;
        start_x = 1; @(negedge clk); start_x = 0;
        wait_done_x("t0_timeout");
        chk("t0_result", {found_x, nonce_x}, {1'b0, 32'd3});
        chk("t0_ready_count", rc_x - base_x, 4);
        // reset mid-WAIT
        target = 8'h10; fail_n = 32'hFFFF_FFFF; win_n = 32'hFFFF_FFFF;
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", {busy, ready}, 2'b10);
        reset = 0;
        #1;
        chk("mid_reset_outputs", outs_all(), '0);
        @(negedge clk);
        reset = 1;
        base = rc;
        repeat (50) @(negedge clk);
        chk("post_reset_no_ready", rc - base, 0);
        chk("post_reset_idle", {busy, done}, 2'b00);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
